// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared state type and select index helpers for the mux select sequencer
package mux_seq_pkg;

    typedef enum logic {IDLE, SHIFT} state_e;

    // First select position of a word
    function automatic int unsigned start_idx(int unsigned n, bit msb_first);
        return msb_first ? (1 << n) - 1 : 0;
    endfunction

    // Final select position of a word
    function automatic int unsigned end_idx(int unsigned n, bit msb_first);
        return msb_first ? 0 : (1 << n) - 1;
    endfunction

endpackage

// File: rtl/mux_select_counter.sv
// mux_select_counter: N-bit up/down select counter with load-to-start, enable and terminal flag
module mux_select_counter
    import mux_seq_pkg::*;
#(
    parameter int N         = 3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    output logic [N-1:0] cnt_o,
    output logic         term_o
);

    localparam logic [N-1:0] START = N'(start_idx(N, MSB_FIRST));
    localparam logic [N-1:0] STOP  = N'(end_idx(N, MSB_FIRST));

    logic [N-1:0] cnt_q, cnt_d;

    // Load has priority over stepping; direction fixed by MSB_FIRST
    always_comb begin
        cnt_d = load_i ? START : en_i ? (MSB_FIRST ? cnt_q - 1'b1 : cnt_q + 1'b1) : cnt_q;
    end

    // Select register, returns to start index on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= START;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign term_o = cnt_q == STOP;

endmodule

// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer: holds a word on a 2^N:1 mux and walks its select to emit a serial stream
module mux_select_sequencer
    import mux_seq_pkg::*;
#(
    parameter int N         = 3,
    parameter bit MSB_FIRST = 1'b0,
    localparam int W        = 2 ** N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] mux_data_in,
    output logic [N-1:0] mux_select,
    input  logic         mux_data_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_data,
    output logic         ser_last
);

    state_e       state_q;
    logic [W-1:0] data_q;
    logic         term, load_fire, ser_fire, word_done;

    // Handshake decode; the last beat frees the word register so a new word can follow with no bubble
    always_comb begin
        ser_valid  = state_q == SHIFT;
        ser_last   = ser_valid & term;
        load_ready = !flush & (!ser_valid | (ser_last & ser_ready));
        load_fire  = load_valid & load_ready;
        ser_fire   = ser_valid & ser_ready;
        word_done  = ser_fire & ser_last;
    end

    // Sequencer FSM and held word; flush aborts but keeps the word on the mux inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else if (load_fire) begin
            state_q <= SHIFT;
            data_q  <= load_data;
        end else if (word_done) begin
            state_q <= IDLE;
        end
    end

    mux_select_counter #(.N(N), .MSB_FIRST(MSB_FIRST)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (flush | load_fire | word_done),
        .en_i   (ser_fire & ~ser_last),
        .cnt_o  (mux_select),
        .term_o (term)
    );

    assign mux_data_in = data_q;
    assign ser_data    = mux_data_out;

endmodule

// File: doc/mux_select_sequencer.md
Name: mux_select_sequencer

Overview:
- Parallel-to-serial front end for the 2^N:1 multiplexer (mux_2n).
- Accepts a 2^N-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the mux select through all 2^N positions.
- Presents each selected bit, which returns combinationally from the mux, as a serial valid/ready stream with a last flag.

Parameters:
- N, 3: select width; word width is 2**N (localparam W = 2**N).
- MSB_FIRST, 0: 0 = select counts 0 up to W-1; 1 = select counts W-1 down to 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of the word in progress.
- load_valid  input  1  upstream word valid.
- load_ready  output  1  sequencer can accept a word.
- load_data  input  W  upstream word.
- mux_data_in  output  W  held word; drives mux data inputs.
- mux_select  output  N  drives mux select.
- mux_data_out  input  1  mux output (combinational from mux_data_in/mux_select).
- ser_valid  output  1  serial bit valid.
- ser_ready  input  1  downstream accepts bit.
- ser_data  output  1  serial bit; equals mux_data_out.
- ser_last  output  1  final bit of current word.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state = IDLE
  - mux_data_in = 0
  - mux_select = start index (0, or W-1 if MSB_FIRST)
  - ser_valid = 0, ser_last = 0
  - load_ready = 1 once rst_n deasserts
- States: IDLE, SHIFT.
- IDLE:
  - load_ready = 1, ser_valid = 0.
  - On load_valid & load_ready: latch load_data into mux_data_in, set mux_select = start index, go to SHIFT next cycle.
- SHIFT:
  - ser_valid = 1, ser_data = mux_data_out, ser_last = (mux_select == end index).
  - end index is W-1, or 0 if MSB_FIRST.
  - On ser_valid & ser_ready with !ser_last: step mux_select by ±1 and stay in SHIFT.
  - If ser_ready is low: mux_select, mux_data_in, ser_valid and ser_last hold unchanged (stall; no bit skipped or repeated).
- Last-beat handshake (ser_last & ser_ready):
  - load_ready is also 1 in this cycle (combinational: state==SHIFT & ser_last & ser_ready).
  - If load_valid in the same cycle: latch the new word, reset mux_select to start index, remain in SHIFT. This gives back-to-back words with no bubble.
  - Otherwise: go to IDLE.
- Latency: first bit valid 1 cycle after load handshake; W bits in W cycles with ser_ready held high.
- Throughput: one word per W cycles sustained.
- Select counter: N-bit; never wraps past the end index in SHIFT.
  - N=1 is legal: W=2, two beats per word.
- flush:
  - Forces state = IDLE, ser_valid = 0, mux_select = start index; mux_data_in retained.
  - flush dominates any simultaneous load or ser handshake. load_ready = 0 in a flush cycle, and no word is accepted.
- Reset mid-word: word discarded, outputs return to reset values immediately (async).
- ser_data in IDLE: don't-care. The bench must only check it when ser_valid = 1.
- Stability: mux_data_in changes only on an accepted load.

Decomposition:
- Package mux_seq_pkg:
  - state enum (IDLE, SHIFT)
  - helper functions for start/end index given N and MSB_FIRST
- One natural sub-module: mux_select_counter.
  - N-bit up/down counter with load-to-start, enable, and terminal flag (drives ser_last).
- Top level:
  - instantiates mux_select_counter
  - holds the FSM and the word register
  - is wired to an external mux_2n #(N) instance in the bench and integration.

Test Plan:
- N=3, MSB_FIRST=0: load 8'hA5, ser_ready=1 -> ser_data sequence 1,0,1,0,0,1,0,1 over 8 consecutive cycles; ser_last only on 8th; then IDLE, load_ready=1.
- MSB_FIRST=1, load 8'hA5 -> sequence 1,0,1,0,0,1,0,1 (MSB first); mux_select 7..0.
- Backpressure: load 8'h3C, ser_ready toggles 1,0,0,1,… -> mux_select holds during stalls; exactly 8 accepted bits equal 8'h3C LSB-first.
- Back-to-back: load_valid held with 8'hFF then 8'h00 -> second load accepted on first word's last beat; 16 bits in 16 cycles with no ser_valid gap.
- flush at beat 3 of 8'h81, with load_valid high in the same cycle -> ser_valid=0 next cycle; no load accepted that cycle; next word starts at select 0.
- rst_n low mid-word -> ser_valid=0 and mux_select=0 asynchronously; after release, load_ready=1 and a new word serializes correctly.
